// File: rtl/rfphoenix_vec_alu_seq.sv
// rfphoenix_vec_alu_seq: strip-mining sequencer that runs one NELEM-element
// vector instruction as NELEM/NLANES_P passes over a shared lane ALU array,
// gathers each pass into the result vector and hands it off valid/ready.
// Optional feature macro: RFPHOENIX_VEC_MASK_EN enables per-element masking,
// the zero/merge policy, and skipping of fully masked chunks.

package rfphoenix_vec_alu_seq_pkg;
  typedef struct packed {
    logic [7:0] op;
    logic [3:0] fn;
    logic [3:0] mods;
  } instruction_t;
endpackage

// Per-element result select: lane result when enabled, otherwise the
// masked-element policy value (zero or the merge source).
module rfphoenix_vec_alu_seq_elem #(
  parameter int ELEM_W = 32
) (
  input  logic              en,
  input  logic              zm,
  input  logic [ELEM_W-1:0] c,
  input  logic [ELEM_W-1:0] res,
  output logic [ELEM_W-1:0] wval
);
  assign wval = en ? res : (zm ? '0 : c);
endmodule

module rfphoenix_vec_alu_seq
  import rfphoenix_vec_alu_seq_pkg::*;
#(
  parameter int NELEM    = 16,
  parameter int NLANES_P = 4,
  parameter int ELEM_W   = 32,
  parameter int TID_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  instruction_t                 in_ir,
  input  logic [TID_W-1:0]             in_tid,
  input  logic [NELEM*ELEM_W-1:0]      in_a,
  input  logic [NELEM*ELEM_W-1:0]      in_b,
  input  logic [NELEM*ELEM_W-1:0]      in_c,
  input  logic [NELEM-1:0]             in_mask,
  input  logic                         in_zm,
  output logic                         lane_go,
  output instruction_t                 lane_ir,
  output logic [NLANES_P*ELEM_W-1:0]   lane_a,
  output logic [NLANES_P*ELEM_W-1:0]   lane_b,
  output logic [NLANES_P*ELEM_W-1:0]   lane_c,
  input  logic [NLANES_P*ELEM_W-1:0]   lane_res,
  input  logic                         lane_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NELEM*ELEM_W-1:0]      out_res,
  output logic [TID_W-1:0]             out_tid,
  output logic                         busy
);
  localparam int NCHUNK = NELEM / NLANES_P;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] KLAST = CW'(NCHUNK - 1);

  // Vectors viewed as [chunk][lane][bits] so a chunk is one index away.
  typedef logic [NCHUNK-1:0][NLANES_P-1:0][ELEM_W-1:0] vec_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    k_q;
  instruction_t                     ir_q;
  logic [TID_W-1:0]                 tid_q;
  vec_t                             a_q, b_q, c_q, res_q;
  logic                             accept, go_d, wr_en, adv, last;
  logic                             chunk_skip, zm_eff;
  logic [NLANES_P-1:0]              elem_en;
  logic [NLANES_P-1:0][ELEM_W-1:0]  lres, wvec;

  assign last = (k_q == KLAST);
  assign lres = lane_res;

`ifdef RFPHOENIX_VEC_MASK_EN
  logic [NCHUNK-1:0][NLANES_P-1:0] mask_q;
  logic                            zm_q;

  // Mask and policy captured with the instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      zm_q   <= 1'b0;
    end else if (accept) begin
      mask_q <= in_mask;
      zm_q   <= in_zm;
    end
  end

  assign elem_en    = mask_q[k_q];
  assign zm_eff     = zm_q;
  assign chunk_skip = ~|mask_q[k_q];
`else
  // Masking compiled out: every element computes, every chunk issues.
  logic unused_mask;
  assign unused_mask = ^{in_mask, in_zm};
  assign elem_en     = '1;
  assign zm_eff      = 1'b0;
  assign chunk_skip  = 1'b0;
`endif

  // Chunk operands come straight from the captured vectors; k only moves on
  // advance, so they stay stable from lane_go through the end of WAIT.
  assign lane_a  = a_q[k_q];
  assign lane_b  = b_q[k_q];
  assign lane_c  = c_q[k_q];
  assign lane_ir = ir_q;

  genvar gi;
  generate
    for (gi = 0; gi < NLANES_P; gi++) begin : g_elem
      rfphoenix_vec_alu_seq_elem #(.ELEM_W(ELEM_W)) u_elem (
        .en   (elem_en[gi]),
        .zm   (zm_eff),
        .c    (c_q[k_q][gi]),
        .res  (lres[gi]),
        .wval (wvec[gi])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, issue pulse and chunk write/advance strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go_d    = 1'b0;
    wr_en   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (chunk_skip) begin
          wr_en = 1'b1;
          adv   = 1'b1;
        end else begin
          go_d    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lane_done) begin
          wr_en = 1'b1;
          adv   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) state_d = last ? S_DONE : S_ISSUE;
  end

  // Operand capture, chunk index and per-chunk result writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      ir_q  <= '0;
      tid_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        ir_q  <= in_ir;
        tid_q <= in_tid;
        a_q   <= in_a;
        b_q   <= in_b;
        c_q   <= in_c;
        k_q   <= '0;
      end
      if (wr_en) res_q[k_q] <= wvec;
      if (adv && !last) k_q <= k_q + 1'b1;
    end
  end

  // Reset gates the combinational handshake outputs so nothing leaks while
  // an abort is pending.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign lane_go   = go_d && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_res   = res_q;
  assign out_tid   = tid_q;

endmodule

// File: tb/tb_rfphoenix_vec_alu_seq.sv
// Bench for rfphoenix_vec_alu_seq: lane array model (a+b after a set delay),
// element-level reference model, per-cycle output compare while out_valid.
module tb_rfphoenix_vec_alu_seq;
  import rfphoenix_vec_alu_seq_pkg::*;

  localparam int NELEM = 16;
  localparam int NL    = 4;
  localparam int EW    = 32;
  localparam int TW    = 4;
  localparam int NCH   = NELEM / NL;
`ifdef RFPHOENIX_VEC_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  typedef logic [NELEM*EW-1:0] vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  instruction_t         in_ir = '0;
  logic [TW-1:0]        in_tid = '0;
  vec_t                 in_a = '0, in_b = '0, in_c = '0;
  logic [NELEM-1:0]     in_mask = '0;
  logic                 in_zm = 1'b0;
  logic                 lane_go;
  instruction_t         lane_ir;
  logic [NL*EW-1:0]     lane_a, lane_b, lane_c;
  logic [NL*EW-1:0]     lane_res = '0;
  logic                 lane_done = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  vec_t                 out_res;
  logic [TW-1:0]        out_tid;
  logic                 busy;

  always #5 clk = ~clk;

  rfphoenix_vec_alu_seq #(.NELEM(NELEM), .NLANES_P(NL), .ELEM_W(EW), .TID_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .in_tid(in_tid), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mask(in_mask),
    .in_zm(in_zm), .lane_go(lane_go), .lane_ir(lane_ir), .lane_a(lane_a),
    .lane_b(lane_b), .lane_c(lane_c), .lane_res(lane_res), .lane_done(lane_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tid(out_tid), .busy(busy)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- lane array model ----------------
  int lane_d = 3;
  bit lane_hold = 1'b0;
  int go_cnt = 0;
  int cnt = 0;
  logic [NL*EW-1:0] pend = '0;

  always @(posedge clk) begin
    lane_done <= lane_hold;
    if (lane_go === 1'b1) begin
      go_cnt++;
      for (int i = 0; i < NL; i++) pend[i*EW +: EW] = lane_a[i*EW +: EW] + lane_b[i*EW +: EW];
      cnt = lane_d;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        lane_done <= 1'b1;
        lane_res  <= pend;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic vec_t model_res(input vec_t a, input vec_t b, input vec_t c,
                                     input logic [NELEM-1:0] m, input logic zm);
    vec_t r;
    bit en;
    for (int e = 0; e < NELEM; e++) begin
      en = MASK_ON ? m[e] : 1'b1;
      if (en)      r[e*EW +: EW] = a[e*EW +: EW] + b[e*EW +: EW];
      else if (zm) r[e*EW +: EW] = '0;
      else         r[e*EW +: EW] = c[e*EW +: EW];
    end
    return r;
  endfunction

  function automatic int model_issued(input logic [NELEM-1:0] m);
    int n = 0;
    for (int k = 0; k < NCH; k++) if (!MASK_ON || (m[k*NL +: NL] != '0)) n++;
    return n;
  endfunction

  // every chunk costs one cycle, an issued one costs d more in WAIT
  function automatic int model_lat(input logic [NELEM-1:0] m, input int d);
    return NCH + model_issued(m) * d;
  endfunction

  function automatic vec_t rvec();
    vec_t r;
    for (int i = 0; i < NELEM; i++) r[i*EW +: EW] = $urandom;
    return r;
  endfunction

  vec_t          exp_res = '0;
  logic [TW-1:0] exp_tid = '0;
  instruction_t  exp_ir = '0;
  bit            exp_live = 1'b0;
  int            go_base = 0;

  // Output compare: every cycle the result is offered it must match the model
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (!exp_live) begin
        checks++;
        errs++;
        $display("FAIL spurious_out_valid: got 1 expected 0");
      end else begin
        chkv("out_res", out_res, exp_res);
        chkn("out_tid", int'(out_tid), int'(exp_tid));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic start_op(input logic [TW-1:0] tid, input vec_t a, input vec_t b,
                          input vec_t c, input logic [NELEM-1:0] m, input logic zm);
    int n = 0;
    logic [31:0] rnd;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("in_ready_before_accept", in_ready, 1'b1);
    rnd      = $urandom;
    in_ir    = instruction_t'(rnd[15:0]);
    in_tid   = tid;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_mask  = m;
    in_zm    = zm;
    in_valid = 1'b1;
    exp_res  = model_res(a, b, c, m, zm);
    exp_tid  = tid;
    exp_ir   = in_ir;
    exp_live = 1'b1;
    go_base  = go_cnt;
    @(posedge clk);
    #1;
    // scramble inputs so the result depends only on captured values
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_c     = ~c;
    in_mask  = ~m;
    in_zm    = ~zm;
    in_tid   = ~tid;
  endtask

  task automatic finish_op(input string nm, input int exp_lat, input int exp_go, input int hold);
    int n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chkn({nm, "_latency"}, n, exp_lat);
    chkn({nm, "_lane_go_count"}, go_cnt - go_base, exp_go);
    chkn({nm, "_lane_ir"}, int'(lane_ir), int'(exp_ir));
    repeat (hold) begin
      @(negedge clk);
      chk1({nm, "_in_ready_held"}, in_ready, 1'b0);
      chk1({nm, "_out_valid_held"}, out_valid, 1'b1);
      chk1({nm, "_busy_held"}, busy, 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_live  = 1'b0;
    chk1({nm, "_out_valid_after"}, out_valid, 1'b0);
    chk1({nm, "_in_ready_after"}, in_ready, 1'b1);
    chk1({nm, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a, b, c, lit;
    logic [NELEM-1:0] m;
    logic [31:0] rnd;
    int n, base;

    // reset behaviour
    repeat (3) @(negedge clk);
    chk1("in_ready_in_reset", in_ready, 1'b0);
    chk1("lane_go_in_reset", lane_go, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_lane_go", lane_go, 1'b0);
    chkv("rst_out_res", out_res, '0);
    chkn("rst_out_tid", int'(out_tid), 0);

    // full mask, a[e]=e, b[e]=100, lane delay 3
    for (int e = 0; e < NELEM; e++) begin
      a[e*EW +: EW]   = e;
      b[e*EW +: EW]   = 100;
      c[e*EW +: EW]   = 32'hC0 + e;
      lit[e*EW +: EW] = 100 + e;
    end
    lane_d = 3;
    start_op(4'h1, a, b, c, 16'hFFFF, 1'b0);
    chkv("model_pin_full", exp_res, lit);
    finish_op("full", 16, 4, 0);

    // one active chunk, merge policy
    for (int e = 0; e < NELEM; e++)
      lit[e*EW +: EW] = (!MASK_ON || (e >= 4 && e <= 7)) ? 100 + e : 32'hC0 + e;
    start_op(4'h2, a, b, c, 16'h00F0, 1'b0);
    chkv("model_pin_merge", exp_res, lit);
    finish_op("merge", MASK_ON ? 7 : 16, MASK_ON ? 1 : 4, 0);

    // same, zero policy
    for (int e = 0; e < NELEM; e++)
      lit[e*EW +: EW] = (!MASK_ON || (e >= 4 && e <= 7)) ? 100 + e : 0;
    start_op(4'h3, a, b, c, 16'h00F0, 1'b1);
    chkv("model_pin_zero", exp_res, lit);
    finish_op("zero", MASK_ON ? 7 : 16, MASK_ON ? 1 : 4, 0);

    // consumer back-pressure for 5 cycles, tag 7
    a = rvec(); b = rvec(); c = rvec();
    start_op(4'h7, a, b, c, 16'hFFFF, 1'b0);
    finish_op("backpressure", 16, 4, 5);

    // lane_done held high: one WAIT cycle per chunk
    lane_hold = 1'b1;
    lane_d    = 1;
    a = rvec(); b = rvec();
    start_op(4'h4, a, b, c, 16'hFFFF, 1'b0);
    finish_op("done_held", 8, 4, 0);
    lane_hold = 1'b0;
    repeat (2) @(negedge clk);

    // reset during WAIT of chunk 2, lane_done arrives the cycle after
    lane_d = 3;
    a = rvec(); b = rvec();
    start_op(4'h5, a, b, c, 16'hFFFF, 1'b0);
    n = 0;
    while (go_cnt - go_base < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chkn("abort_reached_chunk2", go_cnt - go_base, 3);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    exp_live = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = go_cnt;
    repeat (6) begin
      @(negedge clk);
      chk1("abort_lane_go", lane_go, 1'b0);
      chk1("abort_out_valid", out_valid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
    end
    chkn("abort_no_more_go", go_cnt - base, 0);
    chkv("abort_out_res", out_res, '0);
    a = rvec(); b = rvec(); c = rvec();
    start_op(4'h6, a, b, c, 16'hFFFF, 1'b0);
    finish_op("after_abort", 16, 4, 0);

    // everything masked
    lane_d = 2;
    start_op(4'h8, a, b, c, 16'h0000, 1'b0);
    finish_op("all_masked", model_lat(16'h0000, 2), model_issued(16'h0000), 1);

    // randomized operations
    for (int t = 0; t < 14; t++) begin
      rnd = $urandom;
      case (rnd[1:0])
        2'd0:    m = 16'hFFFF;
        2'd1:    m = {4'h0, 4'hF, 4'h0, 4'h3};
        default: m = rnd[31:16];
      endcase
      lane_d = int'($urandom_range(1, 4));
      a = rvec(); b = rvec(); c = rvec();
      start_op(rnd[7:4], a, b, c, m, rnd[8]);
      finish_op("random", model_lat(m, lane_d), model_issued(m), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rfphoenix_vec_alu_seq.md
# rfphoenix_vec_alu_seq

Strip-mining sequencer for multicycle vector ALU operations. It accepts one vector instruction of NELEM elements and issues it as NELEM/NLANES_P successive passes onto a shared array of NLANES_P multicycle lane ALUs. It collects each pass's results into an output vector, applies per-element masking, and returns the completed vector with its thread tag under a valid/ready handshake. It sits between the vector issue stage and writeback, replacing the fixed-delay lane wrapper when vector length exceeds the physical lane count.

## Interface
Parameters:
- NELEM, 16: architectural vector length in elements; must be a multiple of NLANES_P.
- NLANES_P, 4: physical lane ALUs driven per pass.
- ELEM_W, 32: element width in bits.
- TID_W, 4: thread tag width.
- Derived: NCHUNK = NELEM/NLANES_P; CW = max(1, $clog2(NCHUNK)).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept an instruction.
- in_ir  in  $bits(instruction_t)  instruction word.
- in_tid  in  TID_W  thread tag.
- in_a, in_b, in_c  in  NELEM*ELEM_W  source vectors; element e is bits [e*ELEM_W +: ELEM_W].
- in_mask  in  NELEM  element enable; 1 = compute.
- in_zm  in  1  masked-element policy: 1 = zero, 0 = merge (keep in_c element).
- lane_go  out  1  one-cycle start pulse to the lane array.
- lane_ir  out  $bits(instruction_t)  captured instruction.
- lane_a, lane_b, lane_c  out  NLANES_P*ELEM_W  current chunk operands.
- lane_res  in  NLANES_P*ELEM_W  lane results.
- lane_done  in  1  AND of all lane done flags.
- out_valid  out  1  result vector available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  NELEM*ELEM_W  result vector.
- out_tid  out  TID_W  tag of out_res.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture ir, tid, a, b, c, mask and zm; set chunk index k=0; go to ISSUE.
- ISSUE:
  - Chunk k covers elements k*NLANES_P .. k*NLANES_P+NLANES_P-1.
  - If the chunk has any mask bit set: pulse lane_go and go to WAIT.
  - If all chunk mask bits are clear (skip): write the policy values for the chunk, do not pulse lane_go, then advance (see below).
- WAIT:
  - lane_done is sampled only in this state.
  - When lane_done=1, write the chunk result: lane_res for enabled elements, policy value for masked elements. Then advance.
- Advance:
  - If k==NCHUNK-1, go to DONE.
  - Otherwise k<=k+1 and go to ISSUE.
- DONE:
  - out_valid=1; out_res and out_tid held stable.
  - On out_ready, go to IDLE.
- lane_a/b/c are driven from the captured operands indexed by k. They are stable from the lane_go cycle through the WAIT exit.
- lane_done seen outside WAIT, including the lane_go cycle, is ignored.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 in IDLE. lane_go=0, out_valid=0, busy=0, out_res=0, out_tid=0, k=0, state IDLE.
- Reset asserted in any state aborts the operation at the next edge. No lane_go is issued afterwards; an outstanding lane_done is ignored.
- Issued chunk cost: 1 ISSUE cycle plus W cycles in WAIT, where W>=1 is the number of cycles until lane_done is seen.
- Skipped chunk cost: 1 cycle.
- out_valid rises on the edge after the last chunk write.
- Accept on in_valid & in_ready. Complete on out_valid & out_ready, which means in_ready=1 on the next cycle; there is no same-cycle re-accept.
- Latency from accept to out_valid, all chunks issued: sum over chunks of (1 + W).

## Configuration
- RFPHOENIX_VEC_MASK_EN defined:
  - Masking and zm policy active.
  - All-masked chunks are skipped without pulsing lane_go.
- Undefined:
  - in_mask and in_zm are ignored.
  - Every element takes lane_res.
  - Every chunk issues.

## Test plan
- NELEM=16, NLANES_P=4, mask=16'hFFFF, lane model with done 3 cycles after go and res=a+b, a[e]=e, b[e]=100 -> 4 lane_go pulses; out_res[e]=100+e; out_valid 16 cycles after accept.
- mask=16'h00F0, zm=0, c[e]=32'hC0+e, macro on -> exactly one lane_go (k=1); elements 4-7 = a+b; all other elements = c; latency 3+(1+3)=7 cycles.
- Same stimulus with zm=1 -> masked elements = 0. Same stimulus with macro off -> 4 lane_go pulses; every element = a+b.
- Hold out_ready=0 for 5 cycles after out_valid -> out_res and out_tid stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle; a new instruction with tid=4'h7 yields out_tid=7.
- Assert rst for one cycle during WAIT of chunk 2, with lane_done pulsed the following cycle -> idle, out_valid=0, no further lane_go; the next instruction completes normally with a correct result.
- lane_done held 1 continuously -> each issued chunk spends exactly 1 cycle in WAIT; a full 16-element op completes in 8 cycles.
